// File: rtl/maze_game_fsm.sv
// Maze game controller: menu, difficulty select, timed map preview, play, lost, won.
// Each move is checked against a registered-output map ROM before it is committed.
module maze_game_fsm #(
  parameter int MAP_W     = 30,
  parameter int MAP_H     = 21,
  parameter int POS_W     = 8,
  parameter int START_X   = 0,
  parameter int START_Y   = 20,
  parameter int GOAL_X    = 29,
  parameter int GOAL_Y    = 0,
  parameter int SHOW_EASY = 1000000,
  parameter int SHOW_MED  = 500000,
  parameter int SHOW_HARD = 250000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               move_en,
  input  logic                     select,
  output logic [$clog2(MAP_H)-1:0] map_addr,
  input  logic [MAP_W-1:0]         map_data,
  output logic [POS_W-1:0]         player_x,
  output logic [POS_W-1:0]         player_y,
  output logic [1:0]               difficulty,
  output logic [2:0]               state_o,
  output logic                     show_map,
  output logic                     lost,
  output logic                     won
);

  localparam int ADDR_W   = $clog2(MAP_H);
  localparam int SHOW_MAX = (SHOW_EASY > SHOW_MED)
                            ? ((SHOW_EASY > SHOW_HARD) ? SHOW_EASY : SHOW_HARD)
                            : ((SHOW_MED > SHOW_HARD) ? SHOW_MED : SHOW_HARD);
  localparam int TIMER_W  = $clog2(SHOW_MAX + 1);

  localparam logic [POS_W-1:0] X_START = POS_W'(START_X);
  localparam logic [POS_W-1:0] Y_START = POS_W'(START_Y);
  localparam logic [POS_W-1:0] X_GOAL  = POS_W'(GOAL_X);
  localparam logic [POS_W-1:0] Y_GOAL  = POS_W'(GOAL_Y);
  localparam logic [POS_W-1:0] X_MAX   = POS_W'(MAP_W - 1);
  localparam logic [POS_W-1:0] Y_MAX   = POS_W'(MAP_H - 1);

  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_SHOW = 3'd1,
    S_PLAY = 3'd2,
    S_WAIT = 3'd3,
    S_CHK  = 3'd4,
    S_LOST = 3'd5,
    S_WON  = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] show_len_m1;
  logic [POS_W-1:0]   cand_x, cand_y;
  logic [POS_W-1:0]   cand_x_nxt, cand_y_nxt;
  logic               move_ok;
  logic [MAP_W-1:0]   row_shift;
  logic               wall;
  logic               at_goal;

  // Only the highest-priority direction is considered; if it would leave the map the
  // whole pulse is dropped rather than falling through to a lower-priority bit.
  always_comb begin
    move_ok    = 1'b0;
    cand_x_nxt = player_x;
    cand_y_nxt = player_y;
    if (move_en[0]) begin
      if (player_y != '0) begin
        move_ok    = 1'b1;
        cand_y_nxt = player_y - 1'b1;
      end
    end else if (move_en[1]) begin
      if (player_y != Y_MAX) begin
        move_ok    = 1'b1;
        cand_y_nxt = player_y + 1'b1;
      end
    end else if (move_en[2]) begin
      if (player_x != '0) begin
        move_ok    = 1'b1;
        cand_x_nxt = player_x - 1'b1;
      end
    end else if (move_en[3]) begin
      if (player_x != X_MAX) begin
        move_ok    = 1'b1;
        cand_x_nxt = player_x + 1'b1;
      end
    end
  end

  always_comb begin
    row_shift = map_data >> cand_x;
    wall      = row_shift[0];
    at_goal   = (cand_x == X_GOAL) && (cand_y == Y_GOAL);
  end

  always_comb begin
    case (difficulty)
      2'd0:    show_len_m1 = TIMER_W'(SHOW_EASY - 1);
      2'd1:    show_len_m1 = TIMER_W'(SHOW_MED - 1);
      default: show_len_m1 = TIMER_W'(SHOW_HARD - 1);
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_MENU;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_MENU: if (select) state_nxt = S_SHOW;
      S_SHOW: if (timer == '0) state_nxt = S_PLAY;
      S_PLAY: if (move_ok) state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_CHK;
      S_CHK: begin
        if (wall)         state_nxt = S_LOST;
        else if (at_goal) state_nxt = S_WON;
        else              state_nxt = S_PLAY;
      end
      S_LOST, S_WON: if (select) state_nxt = S_MENU;
      default: state_nxt = S_MENU;
    endcase
  end

  // Datapath: difficulty, preview timer, candidate move, ROM address, position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      difficulty <= 2'd0;
      timer      <= '0;
      map_addr   <= '0;
      cand_x     <= X_START;
      cand_y     <= Y_START;
      player_x   <= X_START;
      player_y   <= Y_START;
    end else begin
      case (state)
        S_MENU: begin
          if (move_en[3] && difficulty != 2'd2)      difficulty <= difficulty + 2'd1;
          else if (move_en[2] && difficulty != 2'd0) difficulty <= difficulty - 2'd1;
          if (select) begin
            timer    <= show_len_m1;
            player_x <= X_START;
            player_y <= Y_START;
          end
        end
        S_SHOW: if (timer != '0) timer <= timer - 1'b1;
        S_PLAY: begin
          if (move_ok) begin
            cand_x   <= cand_x_nxt;
            cand_y   <= cand_y_nxt;
            map_addr <= cand_y_nxt[ADDR_W-1:0];
          end
        end
        S_CHK: begin
          if (!wall) begin
            player_x <= cand_x;
            player_y <= cand_y;
          end
        end
        S_LOST, S_WON: begin
          if (select) begin
            player_x <= X_START;
            player_y <= Y_START;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    state_o  = state;
    show_map = (state == S_MENU) || (state == S_SHOW) || (state == S_LOST) || (state == S_WON);
    lost     = (state == S_LOST);
    won      = (state == S_WON);
  end

endmodule

// File: tb/tb_maze_game_fsm.sv
// Self-checking bench for maze_game_fsm: menu/preview timing, move checks against a
// modelled ROM, boundaries, priority, lost/won flow and asynchronous reset.
module tb_maze_game_fsm;

  localparam int MAP_W  = 30;
  localparam int MAP_H  = 21;
  localparam int T_EASY = 20;
  localparam int T_MED  = 12;
  localparam int T_HARD = 8;

  localparam logic [2:0] ST_MENU = 3'd0, ST_SHOW = 3'd1, ST_PLAY = 3'd2, ST_WAIT = 3'd3,
                         ST_CHK = 3'd4, ST_LOST = 3'd5, ST_WON = 3'd6;

  logic             clk;
  logic             reset;
  logic [3:0]       move_en;
  logic             select;
  logic [4:0]       map_addr;
  logic [MAP_W-1:0] map_data;
  logic [7:0]       player_x, player_y;
  logic [1:0]       difficulty;
  logic [2:0]       state_o;
  logic             show_map, lost, won;

  logic [MAP_W-1:0] rom [32];
  logic [18:0]      exp_q[$];
  int               n_checks;
  int               n_fail;

  maze_game_fsm #(
    .SHOW_EASY(T_EASY), .SHOW_MED(T_MED), .SHOW_HARD(T_HARD)
  ) dut (
    .clk(clk), .reset(reset), .move_en(move_en), .select(select),
    .map_addr(map_addr), .map_data(map_data),
    .player_x(player_x), .player_y(player_y), .difficulty(difficulty),
    .state_o(state_o), .show_map(show_map), .lost(lost), .won(won)
  );

  // Clock / reset block and ROM model (registered read, one cycle latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) map_data <= rom[map_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks; all start and end on a falling edge
  task automatic pulse_move(input logic [3:0] dir);
    @(negedge clk) move_en = dir;
    @(negedge clk) move_en = 4'b0000;
  endtask

  task automatic pulse_sel();
    @(negedge clk) select = 1'b1;
    @(negedge clk) select = 1'b0;
  endtask

  // Counts cycles spent in SHOW; optionally drives ignored moves/selects meanwhile.
  task automatic wait_show(input bit noise, output int cnt);
    cnt = 0;
    while (state_o == ST_SHOW && cnt < 1000) begin
      if (noise) begin
        move_en = 4'b0001;
        select  = 1'b1;
      end
      cnt++;
      @(negedge clk);
    end
    move_en = 4'b0000;
    select  = 1'b0;
  endtask

  // Scoreboard: expected {state, x, y} pushed when the move is driven, popped once settled.
  task automatic do_move(input string tag, input logic [3:0] dir,
                         input logic [2:0] es, input logic [7:0] ex, input logic [7:0] ey);
    logic [18:0] e;
    int n;
    exp_q.push_back({es, ex, ey});
    pulse_move(dir);
    repeat (2) @(negedge clk);
    n = 0;
    while ((state_o == ST_WAIT || state_o == ST_CHK) && n < 10) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_state"}, state_o, e[18:16]);
    check_eq({tag, "_x"}, player_x, e[15:8]);
    check_eq({tag, "_y"}, player_y, e[7:0]);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    move_en  = 4'b0000;
    select   = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_state", state_o, ST_MENU);
    check_eq("rst_diff", difficulty, 0);
    check_eq("rst_x", player_x, 0);
    check_eq("rst_y", player_y, 20);
    check_eq("rst_addr", map_addr, 0);
    check_eq("rst_lost_won", {lost, won}, 0);
    check_eq("rst_show_map", show_map, 1);
    reset = 1'b0;

    // Difficulty saturates at hard; hard preview lasts exactly T_HARD cycles
    repeat (3) pulse_move(4'b1000);
    check_eq("diff_sat_hi", difficulty, 2);
    pulse_sel();
    check_eq("enter_show", state_o, ST_SHOW);
    wait_show(1'b1, cnt);
    check_eq("show_hard_len", cnt, T_HARD);
    check_eq("show_to_play", state_o, ST_PLAY);
    check_eq("show_map_play", show_map, 0);
    check_eq("show_ignored_x", player_x, 0);
    check_eq("show_ignored_y", player_y, 20);

    // Open map: boundaries, one step, priority and ignored pulses during WAIT/CHK
    do_move("down_bound", 4'b0010, ST_PLAY, 0, 20);
    do_move("up1", 4'b0001, ST_PLAY, 0, 19);
    check_eq("map_addr_19", map_addr, 19);
    do_move("left_bound", 4'b0100, ST_PLAY, 0, 19);
    exp_q.push_back({ST_PLAY, 8'd0, 8'd18});
    @(negedge clk) move_en = 4'b1111;
    @(negedge clk) begin
      check_eq("prio_wait", state_o, ST_WAIT);
      move_en = 4'b1000;
    end
    @(negedge clk) begin
      check_eq("prio_chk", state_o, ST_CHK);
      move_en = 4'b1000;
    end
    @(negedge clk) begin
      move_en = 4'b0000;
      begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check_eq("prio_state", state_o, e[18:16]);
        check_eq("prio_x", player_x, e[15:8]);
        check_eq("prio_y", player_y, e[7:0]);
      end
    end
    do_move("right1", 4'b1000, ST_PLAY, 1, 18);
    for (int i = 0; i < 18; i++) do_move("walk_up", 4'b0001, ST_PLAY, 1, 8'(17 - i));
    for (int i = 0; i < 27; i++) do_move("walk_right", 4'b1000, ST_PLAY, 8'(2 + i), 0);
    do_move("up_underflow", 4'b0001, ST_PLAY, 28, 0);
    do_move("goal", 4'b1000, ST_WON, 29, 0);
    check_eq("won_flag", won, 1);
    check_eq("won_lost_flag", lost, 0);
    check_eq("won_show_map", show_map, 1);
    do_move("won_hold", 4'b0010, ST_WON, 29, 0);
    pulse_sel();
    check_eq("won_to_menu", state_o, ST_MENU);
    check_eq("won_keep_diff", difficulty, 2);
    check_eq("won_reload_x", player_x, 0);
    check_eq("won_reload_y", player_y, 20);

    // Wall hit: easy preview, LOST, back to menu
    repeat (3) pulse_move(4'b0100);
    check_eq("diff_sat_lo", difficulty, 0);
    rom[19] = 30'h1;
    pulse_sel();
    wait_show(1'b0, cnt);
    check_eq("show_easy_len", cnt, T_EASY);
    do_move("wall", 4'b0001, ST_LOST, 0, 20);
    check_eq("lost_flag", lost, 1);
    check_eq("lost_won_flag", won, 0);
    pulse_sel();
    check_eq("lost_to_menu", state_o, ST_MENU);
    check_eq("lost_reload_y", player_y, 20);

    // Asynchronous reset mid-SHOW
    pulse_move(4'b1000);
    check_eq("diff_med", difficulty, 1);
    pulse_sel();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_show_state", state_o, ST_MENU);
    check_eq("rst_show_diff", difficulty, 0);
    @(negedge clk) reset = 1'b0;

    // Asynchronous reset while a move is in CHK: the move must not commit
    pulse_move(4'b1000);
    rom[19] = '0;
    pulse_sel();
    wait_show(1'b0, cnt);
    check_eq("show_med_len", cnt, T_MED);
    @(negedge clk) move_en = 4'b0001;
    @(negedge clk) move_en = 4'b0000;
    @(negedge clk) check_eq("pre_rst_chk", state_o, ST_CHK);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_chk_state", state_o, ST_MENU);
    check_eq("rst_chk_diff", difficulty, 0);
    check_eq("rst_chk_x", player_x, 0);
    check_eq("rst_chk_y", player_y, 20);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_y", player_y, 20);
    check_eq("post_rst_state", state_o, ST_MENU);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
